// File: rtl/gated_universal_register.sv
// Universal register with clock enable: hold/load/shift/rotate/count and carry.
// Optional parity output is enabled by the GATED_UNIREG_PARITY_EN macro.
module gated_universal_register #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             notReset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data,
   input  logic             serialIn,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] notout,
   output logic             serialOut,
   output logic             carry
`ifdef GATED_UNIREG_PARITY_EN
   ,
   output logic             parity
`endif
);

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_LOAD  = 3'b001,
      OP_SHL   = 3'b010,
      OP_SHR   = 3'b011,
      OP_ROL   = 3'b100,
      OP_ROR   = 3'b101,
      OP_INC   = 3'b110,
      OP_DEC   = 3'b111
   } op_e;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   op_e              op;
   logic [WIDTH-1:0] next_out;
   logic             next_carry;

   assign op = op_e'(mode);

   always_comb begin
      next_out   = out;
      next_carry = 1'b0;
      unique case (op)
         OP_HOLD: next_out = out;
         OP_LOAD: next_out = data;
         OP_SHL: begin
            next_out   = {out[WIDTH-2:0], serialIn};
            next_carry = out[WIDTH-1];
         end
         OP_SHR: begin
            next_out   = {serialIn, out[WIDTH-1:1]};
            next_carry = out[0];
         end
         OP_ROL:  next_out = {out[WIDTH-2:0], out[WIDTH-1]};
         OP_ROR:  next_out = {out[0], out[WIDTH-1:1]};
         OP_INC: begin
            next_out   = out + ONE;
            next_carry = &out;
         end
         OP_DEC: begin
            next_out   = out - ONE;
            next_carry = ~|out;
         end
         default: next_out = out;
      endcase
   end

   // Carry is only rewritten on enabled edges, so a pulse persists while gated off.
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         out   <= '0;
         carry <= 1'b0;
      end else if (enable) begin
         out   <= next_out;
         carry <= next_carry;
      end
   end

   assign notout    = ~out;
   assign serialOut = out[WIDTH-1];
`ifdef GATED_UNIREG_PARITY_EN
   assign parity    = ^out;
`endif

endmodule

// File: tb/tb_gated_universal_register.sv
// Self-checking bench for gated_universal_register: directed cases then random
// stimulus against an arithmetic reference model.
module tb_gated_universal_register;

   localparam int unsigned W = 8;
   localparam longint unsigned M = 64'd1 << W;

   logic         clock;
   logic         notReset;
   logic         enable;
   logic [2:0]   mode;
   logic [W-1:0] data;
   logic         serialIn;
   logic [W-1:0] out;
   logic [W-1:0] notout;
   logic         serialOut;
   logic         carry;
`ifdef GATED_UNIREG_PARITY_EN
   logic         parity;
`endif

   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned fails  = 0;

   longint unsigned m_out   = 0;
   longint unsigned m_carry = 0;

   gated_universal_register #(.WIDTH(W)) dut (
      .clock     (clock),
      .notReset  (notReset),
      .enable    (enable),
      .mode      (mode),
      .data      (data),
      .serialIn  (serialIn),
      .out       (out),
      .notout    (notout),
      .serialOut (serialOut),
      .carry     (carry)
`ifdef GATED_UNIREG_PARITY_EN
      ,
      .parity    (parity)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      longint unsigned ones = 0;
      chk({tag, ".out"}, 64'(out), m_out);
      chk({tag, ".notout"}, 64'(notout), (M - 1) - m_out);
      chk({tag, ".serialOut"}, 64'(serialOut), m_out / (M / 2));
      chk({tag, ".carry"}, 64'(carry), m_carry);
`ifdef GATED_UNIREG_PARITY_EN
      for (longint unsigned v = m_out; v != 0; v = v / 2) ones += v % 2;
      chk({tag, ".parity"}, 64'(parity), ones % 2);
`else
      ones = 0;
`endif
   endtask

   // Reference behaviour expressed as integer arithmetic on the register value.
   task automatic model_edge(input logic en, input logic [2:0] md,
                             input longint unsigned d, input longint unsigned si);
      longint unsigned o = m_out;
      if (!en) return;
      case (md)
         3'd0: m_carry = 0;
         3'd1: begin m_out = d; m_carry = 0; end
         3'd2: begin m_carry = (o >= M / 2) ? 1 : 0; m_out = (o * 2 + si) % M; end
         3'd3: begin m_carry = o % 2; m_out = o / 2 + si * (M / 2); end
         3'd4: begin m_out = (o * 2) % M + o / (M / 2); m_carry = 0; end
         3'd5: begin m_out = o / 2 + (o % 2) * (M / 2); m_carry = 0; end
         3'd6: begin m_carry = (o == M - 1) ? 1 : 0; m_out = (o + 1) % M; end
         default: begin m_carry = (o == 0) ? 1 : 0; m_out = (o + M - 1) % M; end
      endcase
   endtask

   task automatic do_edge(input string tag, input logic en, input logic [2:0] md,
                          input logic [W-1:0] d, input logic si);
      enable   = en;
      mode     = md;
      data     = d;
      serialIn = si;
      @(posedge clock);
      #1;
      model_edge(en, md, longint'(d), longint'(si));
      check_all(tag);
   endtask

   task automatic reset_pulse(input string tag);
      #2 notReset = 1'b0;
      #1;
      m_out   = 0;
      m_carry = 0;
      check_all(tag);
      #1 notReset = 1'b1;
   endtask

   initial begin
      notReset = 1'b0;
      enable   = 1'b0;
      mode     = 3'd0;
      data     = '0;
      serialIn = 1'b0;
      #1;
      check_all("reset");
      #3 notReset = 1'b1;

      do_edge("load_a5", 1'b1, 3'd1, 8'hA5, 1'b0);
      for (int i = 0; i < 3; i++) do_edge("gated_shl", 1'b0, 3'd2, 8'h00, 1'b1);
      do_edge("shl", 1'b1, 3'd2, 8'h00, 1'b1);
      do_edge("shr", 1'b1, 3'd3, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) do_edge("carry_persist", 1'b0, 3'd6, 8'h00, 1'b0);
      do_edge("load_81", 1'b1, 3'd1, 8'h81, 1'b0);
      do_edge("rol", 1'b1, 3'd4, 8'h00, 1'b1);
      do_edge("ror", 1'b1, 3'd5, 8'h00, 1'b0);
      do_edge("load_fe", 1'b1, 3'd1, 8'hFE, 1'b0);
      for (int i = 0; i < 3; i++) do_edge("inc_wrap", 1'b1, 3'd6, 8'h00, 1'b0);
      do_edge("load_01", 1'b1, 3'd1, 8'h01, 1'b0);
      for (int i = 0; i < 2; i++) do_edge("dec_wrap", 1'b1, 3'd7, 8'h00, 1'b0);
      do_edge("hold", 1'b1, 3'd0, 8'h55, 1'b1);
      do_edge("load_07", 1'b1, 3'd1, 8'h07, 1'b0);
      do_edge("load_3c", 1'b1, 3'd1, 8'h3C, 1'b0);
      reset_pulse("async_reset");
      do_edge("post_reset_dec", 1'b1, 3'd7, 8'h00, 1'b0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) reset_pulse("rand_reset");
         else do_edge("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      W'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
